// File: rtl/axi_pkg.sv
// Shared AXI constants, burst helper and FSM state types for the memory responder.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  // Reserved burst encoding 2'b11 steps like INCR; WRAP also just steps by one word.
  function automatic logic burst_advances(input logic [1:0] burst);
    return (burst == AXI_BURST_INCR) || (burst == AXI_BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port with read enable.
module axi_mem_bram #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Output register holds its value unless a new read is issued (read-first on collision).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave terminating writes and reads into an on-chip word-addressed memory.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int unsigned C_S_AXI_ID_WIDTH    = 8,
  parameter int unsigned C_S_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXI_WSTRB_WIDTH = C_S_AXI_DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH_LOG2      = 10
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic                           s_AWVALID,
  output logic                           s_AWREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]  s_AWADDR,
  input  logic [1:0]                     s_AWBURST,
  input  logic [7:0]                     s_AWLEN,
  input  logic [2:0]                     s_AWSIZE,
  input  logic [C_S_AXI_ID_WIDTH-1:0]    s_AWID,
  input  logic                           s_WVALID,
  output logic                           s_WREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]  s_WDATA,
  input  logic [C_S_AXI_WSTRB_WIDTH-1:0] s_WSTRB,
  input  logic                           s_WLAST,
  output logic                           s_BVALID,
  input  logic                           s_BREADY,
  output logic [1:0]                     s_BRESP,
  output logic [C_S_AXI_ID_WIDTH-1:0]    s_BID,
  input  logic                           s_ARVALID,
  output logic                           s_ARREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]  s_ARADDR,
  input  logic [1:0]                     s_ARBURST,
  input  logic [7:0]                     s_ARLEN,
  input  logic [2:0]                     s_ARSIZE,
  input  logic [C_S_AXI_ID_WIDTH-1:0]    s_ARID,
  output logic                           s_RVALID,
  input  logic                           s_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]  s_RDATA,
  output logic                           s_RLAST,
  output logic [C_S_AXI_ID_WIDTH-1:0]    s_RID,
  output logic [1:0]                     s_RRESP
);

  localparam int unsigned IDX_W = MEM_DEPTH_LOG2;
  localparam int unsigned OFF_W = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int unsigned CNT_W = 9;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
    return burst_advances(burst) ? idx + IDX_W'(1) : idx;
  endfunction

  // Size and byte-offset bits play no part in addressing; every beat is full width.
  logic w_unused;
  assign w_unused = ^{s_AWADDR, s_AWSIZE, s_ARADDR, s_ARSIZE};

  // ---------------- write channel ----------------
  w_state_e                    r_wstate, w_wstate_nxt;
  logic [IDX_W-1:0]            r_widx;
  logic [7:0]                  r_wlen, r_wcnt;
  logic [1:0]                  r_wburst;
  logic                        r_werr;
  logic                        r_awready, r_wready, r_bvalid;
  logic [1:0]                  r_bresp;
  logic [C_S_AXI_ID_WIDTH-1:0] r_bid;
  logic                        w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_beat_err;

  assign w_aw_hs      = s_AWVALID & r_awready;
  assign w_w_hs       = s_WVALID & r_wready;
  assign w_b_hs       = r_bvalid & s_BREADY;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_beat_err   = s_WLAST ^ w_wlast_beat;

  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_bid     <= '0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wburst  <= AXI_BURST_INCR;
      r_werr    <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_widx   <= s_AWADDR[OFF_W +: IDX_W];
        r_wlen   <= s_AWLEN;
        r_wburst <= s_AWBURST;
        r_bid    <= s_AWID;
        r_wcnt   <= '0;
        r_werr   <= 1'b0;
      end
      if (w_w_hs) begin
        r_widx <= next_idx(r_widx, r_wburst);
        r_wcnt <= r_wcnt + 8'(1);
        r_werr <= r_werr | w_beat_err;
        if (w_wlast_beat) r_bresp <= (r_werr | w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e                    r_rstate, w_rstate_nxt;
  logic [IDX_W-1:0]            r_ridx;
  logic [7:0]                  r_rlen;
  logic [CNT_W-1:0]            r_rissue;
  logic [1:0]                  r_rburst;
  logic                        r_arready, r_rvalid, r_rlast;
  logic [C_S_AXI_ID_WIDTH-1:0] r_rid;
  logic                        w_ar_hs, w_r_hs, w_issue;

  assign w_ar_hs = s_ARVALID & r_arready;
  assign w_r_hs  = r_rvalid & s_RREADY;
  assign w_issue = (r_rstate == R_BURST) && (r_rissue <= {1'b0, r_rlen}) && (!r_rvalid || s_RREADY);

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_BURST;
      R_BURST: if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // A beat issued this edge appears on RDATA/RVALID next cycle via the RAM output register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rburst  <= AXI_BURST_INCR;
      r_rissue  <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_ridx   <= s_ARADDR[OFF_W +: IDX_W];
        r_rlen   <= s_ARLEN;
        r_rburst <= s_ARBURST;
        r_rid    <= s_ARID;
        r_rissue <= '0;
      end
      if (w_issue) begin
        r_ridx   <= next_idx(r_ridx, r_rburst);
        r_rissue <= r_rissue + CNT_W'(1);
        r_rvalid <= 1'b1;
        r_rlast  <= (r_rissue[7:0] == r_rlen);
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  axi_mem_bram #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .ADDR_WIDTH (IDX_W)
  ) u_bram (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_we    (w_w_hs),
    .i_waddr (r_widx),
    .i_wdata (s_WDATA),
    .i_wbe   (s_WSTRB),
    .i_re    (w_issue),
    .i_raddr (r_ridx),
    .o_rdata (s_RDATA)
  );

  assign s_AWREADY = r_awready;
  assign s_WREADY  = r_wready;
  assign s_BVALID  = r_bvalid;
  assign s_BRESP   = r_bresp;
  assign s_BID     = r_bid;
  assign s_ARREADY = r_arready;
  assign s_RVALID  = r_rvalid;
  assign s_RLAST   = r_rlast;
  assign s_RID     = r_rid;
  assign s_RRESP   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed + randomized bench for axi_mem_responder against a word-array memory model.
module tb_axi_mem_responder;
  import axi_pkg::*;

  localparam int unsigned IDW   = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 512;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DL2   = 10;
  localparam int unsigned DEPTH = 1 << DL2;

  logic           ap_clk = 1'b0;
  logic           ap_rst = 1'b1;
  logic           s_AWVALID = 0, s_AWREADY;
  logic [AW-1:0]  s_AWADDR = '0;
  logic [1:0]     s_AWBURST = '0;
  logic [7:0]     s_AWLEN = '0;
  logic [2:0]     s_AWSIZE = '0;
  logic [IDW-1:0] s_AWID = '0;
  logic           s_WVALID = 0, s_WREADY;
  logic [DW-1:0]  s_WDATA = '0;
  logic [SW-1:0]  s_WSTRB = '0;
  logic           s_WLAST = 0;
  logic           s_BVALID, s_BREADY = 0;
  logic [1:0]     s_BRESP;
  logic [IDW-1:0] s_BID;
  logic           s_ARVALID = 0, s_ARREADY;
  logic [AW-1:0]  s_ARADDR = '0;
  logic [1:0]     s_ARBURST = '0;
  logic [7:0]     s_ARLEN = '0;
  logic [2:0]     s_ARSIZE = '0;
  logic [IDW-1:0] s_ARID = '0;
  logic           s_RVALID, s_RREADY = 0;
  logic [DW-1:0]  s_RDATA;
  logic           s_RLAST;
  logic [IDW-1:0] s_RID;
  logic [1:0]     s_RRESP;

  axi_mem_responder #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_WSTRB_WIDTH(SW), .MEM_DEPTH_LOG2(DL2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWBURST(s_AWBURST),
    .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE), .s_AWID(s_AWID),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP), .s_BID(s_BID),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARBURST(s_ARBURST),
    .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE), .s_ARID(s_ARID),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RLAST(s_RLAST),
    .s_RID(s_RID), .s_RRESP(s_RRESP)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] wdat  [256];
  logic [SW-1:0] wstb  [256];

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / 64) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int j = 0; j < DW / 32; j++) w[32*j +: 32] = $urandom();
    return w;
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input logic [7:0] id, input int wlast_at, input int bdelay, input bit gaps);
    int  idx, tmo;
    bit  err;
    idx = widx(addr);
    err = 0;
    for (int b = 0; b <= len; b++) begin
      for (int j = 0; j < SW; j++) if (wstb[b][j]) mem_m[idx][8*j +: 8] = wdat[b][8*j +: 8];
      if ((b == wlast_at) != (b == len)) err = 1;
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    s_AWADDR = addr; s_AWLEN = 8'(len); s_AWBURST = burst; s_AWID = id; s_AWSIZE = 3'd6; s_AWVALID = 1;
    tmo = 0;
    while (!s_AWREADY && tmo < 200) begin @(negedge ap_clk); tmo++; end
    chk_b("aw_ready", s_AWREADY, 1'b1);
    @(negedge ap_clk);
    s_AWVALID = 0;
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin s_WVALID = 0; @(negedge ap_clk); end
      s_WDATA = wdat[b]; s_WSTRB = wstb[b]; s_WLAST = (b == wlast_at); s_WVALID = 1;
      tmo = 0;
      while (!s_WREADY && tmo < 200) begin @(negedge ap_clk); tmo++; end
      chk_b("w_ready", s_WREADY, 1'b1);
      @(negedge ap_clk);
      chk_b("w_ready_after_beat", s_WREADY, b < len);
    end
    s_WVALID = 0; s_WLAST = 0;
    s_BREADY = 0;
    for (int c = 0; c < bdelay; c++) begin
      chk_b("b_held", s_BVALID, 1'b1);
      chk_b("aw_blocked", s_AWREADY, 1'b0);
      @(negedge ap_clk);
    end
    chk_b("bvalid", s_BVALID, 1'b1);
    chk_d("bid", DW'(s_BID), DW'(id));
    chk_d("bresp", DW'(s_BRESP), err ? DW'(2'b10) : DW'(2'b00));
    s_BREADY = 1;
    @(negedge ap_clk);
    s_BREADY = 0;
    chk_b("b_dropped", s_BVALID, 1'b0);
    chk_b("aw_rearmed", s_AWREADY, 1'b1);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1 repeating
  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                         input logic [7:0] id, input int rmode);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held;
    logic          held_last, rr;
    int            idx, beat, tmo, cyc, first, gaps;
    bit            stalled;
    idx = widx(addr);
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back(mem_m[idx]);
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    s_ARADDR = addr; s_ARLEN = 8'(len); s_ARBURST = burst; s_ARID = id; s_ARSIZE = 3'd6; s_ARVALID = 1;
    tmo = 0;
    while (!s_ARREADY && tmo < 200) begin @(negedge ap_clk); tmo++; end
    chk_b("ar_ready", s_ARREADY, 1'b1);
    @(negedge ap_clk);
    s_ARVALID = 0;
    cyc = 1; first = -1; beat = 0; gaps = 0; stalled = 0; held = '0; held_last = 0;
    while (beat <= len && cyc < 2000) begin
      if (s_RVALID) begin
        if (first < 0) first = cyc;
        chk_d("rdata", s_RDATA, exp_q[beat]);
        chk_b("rlast", s_RLAST, beat == len);
        chk_d("rid", DW'(s_RID), DW'(id));
        chk_d("rresp", DW'(s_RRESP), DW'(2'b00));
        if (stalled) begin
          chk_d("rdata_stable", s_RDATA, held);
          chk_b("rlast_stable", s_RLAST, held_last);
        end
      end else if (first >= 0) gaps++;
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(0, 1));
        default: rr = (first < 0) ? 1'b1 : (((cyc - first) % 4 == 0) || ((cyc - first) % 4 == 3));
      endcase
      s_RREADY  = rr;
      stalled   = s_RVALID && !rr;
      held      = s_RDATA;
      held_last = s_RLAST;
      if (s_RVALID && rr) beat++;
      @(negedge ap_clk);
      cyc++;
    end
    s_RREADY = 0;
    chk_i("r_beats", beat, len + 1);
    chk_i("r_first_latency", first, 2);
    if (rmode == 0) chk_i("r_gapless", gaps, 0);
    chk_b("r_done", s_RVALID, 1'b0);
    chk_b("ar_rearmed", s_ARREADY, 1'b1);
  endtask

  task automatic do_read_reset(input logic [AW-1:0] addr, input logic [7:0] id);
    int beat, tmo;
    s_ARADDR = addr; s_ARLEN = 8'd7; s_ARBURST = AXI_BURST_INCR; s_ARID = id; s_ARVALID = 1; s_RREADY = 1;
    tmo = 0;
    while (!s_ARREADY && tmo < 200) begin @(negedge ap_clk); tmo++; end
    chk_b("rst_ar_ready", s_ARREADY, 1'b1);
    @(negedge ap_clk);
    s_ARVALID = 0;
    beat = 0; tmo = 0;
    while (!(s_RVALID && beat == 2) && tmo < 50) begin
      if (s_RVALID) beat++;
      @(negedge ap_clk);
      tmo++;
    end
    chk_b("rst_on_beat2", s_RVALID, 1'b1);
    s_RREADY = 0;
    #2 ap_rst = 1;
    #1;
    chk_b("rst_rvalid", s_RVALID, 1'b0);
    chk_b("rst_arready", s_ARREADY, 1'b0);
    chk_b("rst_awready", s_AWREADY, 1'b0);
    chk_b("rst_rlast", s_RLAST, 1'b0);
    chk_d("rst_rdata", s_RDATA, '0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 0;
    @(negedge ap_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] addr;
    int            len, wl;
    logic [1:0]    burst;

    repeat (3) @(negedge ap_clk);
    chk_b("reset_awready", s_AWREADY, 1'b0);
    chk_b("reset_wready", s_WREADY, 1'b0);
    chk_b("reset_bvalid", s_BVALID, 1'b0);
    chk_b("reset_arready", s_ARREADY, 1'b0);
    chk_b("reset_rvalid", s_RVALID, 1'b0);
    chk_b("reset_rlast", s_RLAST, 1'b0);
    chk_d("reset_bresp", DW'(s_BRESP), '0);
    chk_d("reset_bid", DW'(s_BID), '0);
    chk_d("reset_rid", DW'(s_RID), '0);
    chk_d("reset_rresp", DW'(s_RRESP), '0);
    chk_d("reset_rdata", s_RDATA, '0);
    ap_rst = 0;
    @(negedge ap_clk);

    // single beat write/read
    wdat[0] = rand_word(); wstb[0] = '1;
    do_write(32'h40, 0, AXI_BURST_INCR, 8'h05, 0, 0, 0);
    do_read(32'h40, 0, AXI_BURST_INCR, 8'h3C, 0);

    // INCR burst with data k on beat k, B held off for 5 cycles
    for (int k = 0; k < 8; k++) begin wdat[k] = DW'(k); wstb[k] = '1; end
    do_write(32'h0, 7, AXI_BURST_INCR, 8'h11, 7, 5, 0);
    do_read(32'h0, 7, AXI_BURST_INCR, 8'h22, 0);

    // read backpressure 1,0,0,1
    do_read(32'h0, 3, AXI_BURST_INCR, 8'h33, 2);

    // byte strobe with FIXED burst on word 2
    wdat[0] = '1; wstb[0] = '1;
    do_write(32'h80, 0, AXI_BURST_INCR, 8'h44, 0, 0, 0);
    wdat[0] = '0; wdat[1] = DW'(8'h11); wstb[0] = SW'(1); wstb[1] = SW'(1);
    do_write(32'h80, 1, AXI_BURST_FIXED, 8'h45, 1, 1, 0);
    do_read(32'h80, 0, AXI_BURST_INCR, 8'h46, 0);

    // early WLAST on beat 1 of a len-3 burst
    for (int k = 0; k < 4; k++) begin wdat[k] = rand_word(); wstb[k] = '1; end
    do_write(32'h200, 3, AXI_BURST_INCR, 8'h55, 1, 0, 1);
    do_read(32'h200, 3, AXI_BURST_INCR, 8'h56, 1);

    // randomized bursts: full fill, then partial-strobe overwrite, then read back
    for (int it = 0; it < 10; it++) begin
      addr  = $urandom();
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 3));
      for (int b = 0; b <= len; b++) begin wdat[b] = rand_word(); wstb[b] = '1; end
      do_write(addr, len, burst, 8'($urandom()), len, $urandom_range(0, 3), 1);
      for (int b = 0; b <= len; b++) begin wdat[b] = rand_word(); wstb[b] = {$urandom(), $urandom()}; end
      wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
      do_write(addr, len, burst, 8'($urandom()), wl, $urandom_range(0, 2), 1);
      do_read(addr, len, burst, 8'($urandom()), $urandom_range(0, 1));
    end

    // concurrent write and read on disjoint words
    for (int k = 0; k < 4; k++) begin wdat[k] = rand_word(); wstb[k] = '1; end
    fork
      do_write(32'h0001_2000, 3, AXI_BURST_INCR, 8'h77, 3, 1, 1);
      do_read(32'h0, 7, AXI_BURST_INCR, 8'h78, 1);
    join
    do_read(32'h0001_2000, 3, AXI_BURST_INCR, 8'h79, 0);

    // reset in the middle of a read burst; memory must survive
    do_read_reset(32'h0, 8'h88);
    do_read(32'h0, 7, AXI_BURST_INCR, 8'h89, 0);
    do_read(32'h80, 0, AXI_BURST_INCR, 8'h8A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
